// File: rtl/mcs4_pkg.sv
// Shared MCS-4 ROM definitions: bus widths and the host access FSM states.
package mcs4_pkg;

    localparam int unsigned ROM_ADDR_W = 12;
    localparam int unsigned ROM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        CAPT  = 2'd2,
        ACK   = 2'd3
    } host_state_e;

endpackage

// File: rtl/i4001_rom_window.sv
// Tracks the CPU ROM access window (first A3 cycle through the cycle after M2 falls)
// and flags the cycles in which a host access may be granted.
module i4001_rom_window (
    input  logic sysclk,
    input  logic poc,
    input  logic a22,
    input  logic a32,
    input  logic m11,
    input  logic m22,
    output logic win,
    output logic host_ok
);

    logic win_q;
    logic m22_q;

    always_ff @(posedge sysclk) begin
        if (poc) begin
            win_q <= 1'b0;
            m22_q <= 1'b0;
        end else begin
            m22_q <= m22;
            if (a32) begin
                win_q <= 1'b1;
            end else if (m22_q && !m22) begin
                win_q <= 1'b0;
            end
        end
    end

    // a32 opens the window combinationally so its first cycle already belongs to the CPU
    assign win = win_q | a32;

    // A2 is excluded so a 3-cycle host access always finishes before A3 starts
    assign host_ok = ~win & ~a22 & ~a32 & ~m11;

endmodule

// File: rtl/i4001_rom_ctrl.sv
// Arbitrates one synchronous BRAM between i4001 fetches and a host maintenance port.
// Build option: MCS4_ROM_HOST_WRITE_EN enables host writes; otherwise writes are refused.
module i4001_rom_ctrl
    import mcs4_pkg::*;
#(
    parameter int unsigned ADDR_W = ROM_ADDR_W,
    parameter int unsigned DATA_W = ROM_DATA_W
) (
    input  logic              sysclk,
    input  logic              poc,
    input  logic              a22,
    input  logic              a32,
    input  logic              m11,
    input  logic              m22,
    input  logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_we,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic              host_err,
    output logic [DATA_W-1:0] host_rdata
);

    host_state_e state_q;
    host_state_e state_d;
    logic        win;
    logic        host_ok;
    logic        write_refused_c;

    i4001_rom_window u_window (
        .sysclk  (sysclk),
        .poc     (poc),
        .a22     (a22),
        .a32     (a32),
        .m11     (m11),
        .m22     (m22),
        .win     (win),
        .host_ok (host_ok)
    );

`ifdef MCS4_ROM_HOST_WRITE_EN
    assign write_refused_c = 1'b0;
`else
    assign write_refused_c = host_we;
`endif

    always_ff @(posedge sysclk) begin
        if (poc) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (host_req && host_ok) state_d = GRANT;
            GRANT:   state_d = CAPT;
            CAPT:    state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // BRAM port mux: CPU owns it inside the window, the host only in GRANT
    always_comb begin
        bram_addr  = '0;
        bram_we    = 1'b0;
        bram_wdata = '0;
        if (!poc) begin
            if (win) begin
                bram_addr = rom_addr;
            end else if (state_q == GRANT) begin
                bram_addr  = host_addr;
                bram_wdata = host_wdata;
`ifdef MCS4_ROM_HOST_WRITE_EN
                bram_we    = host_we;
`endif
            end
        end
    end

    // Read data returns during CAPT, so results are registered there to be valid with the ack
    always_ff @(posedge sysclk) begin
        if (poc) begin
            rom_data   <= '0;
            host_ack   <= 1'b0;
            host_err   <= 1'b0;
            host_rdata <= '0;
        end else begin
            if (win) begin
                rom_data <= bram_rdata;
            end
            host_ack <= (state_q == CAPT);
            host_err <= (state_q == CAPT) && write_refused_c;
            if (state_q == CAPT && !host_we) begin
                host_rdata <= bram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_i4001_rom_ctrl.sv
// Directed bench for i4001_rom_ctrl with a BRAM model and a 32-cycle instruction phase generator.
module tb_i4001_rom_ctrl;

    logic        sysclk = 1'b0;
    logic        poc;
    logic        a22, a32, m11, m22;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic [11:0] bram_addr;
    logic        bram_we;
    logic [7:0]  bram_wdata;
    logic [7:0]  bram_rdata;
    logic        host_req, host_we;
    logic [11:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack, host_err;
    logic [7:0]  host_rdata;

    logic [7:0]  mem [0:4095];
    logic        mem_init;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ph = 0;
    int          we_in_win = 0;
    logic [11:0] cpu_addr;

    i4001_rom_ctrl dut (
        .sysclk     (sysclk),
        .poc        (poc),
        .a22        (a22),
        .a32        (a32),
        .m11        (m11),
        .m22        (m22),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .bram_addr  (bram_addr),
        .bram_we    (bram_we),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_err   (host_err),
        .host_rdata (host_rdata)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) begin
        if (mem_init) begin
            mem[12'h000] <= 8'h5A;
            mem[12'h123] <= 8'hA5;
            mem[12'h0FF] <= 8'h11;
            mem[12'h010] <= 8'h42;
            mem[12'h0AA] <= 8'h77;
            mem[12'h300] <= 8'h0D;
            mem[12'h201] <= 8'hC3;
            mem[12'h202] <= 8'h96;
        end else if (bram_we) begin
            mem[bram_addr] <= bram_wdata;
        end
        bram_rdata <= mem[bram_addr];
    end

    // A1..X3 at 4 sysclk per phase: A2=4..7, A3=8..11, M1=12..15, M2=16..19
    function automatic bit eligible(input int c);
        int p;
        p = c % 32;
        return (p < 4) || (p >= 21);
    endfunction

    function automatic int pred_ack(input int c0);
        int c;
        c = c0;
        while (!eligible(c)) c++;
        return c + 3;
    endfunction

    task automatic drive_phase();
        ph       = cyc % 32;
        a22      = (ph >= 4  && ph < 8);
        a32      = (ph >= 8  && ph < 12);
        m11      = (ph >= 12 && ph < 16);
        m22      = (ph >= 16 && ph < 20);
        rom_addr = (ph >= 8 && ph <= 20) ? cpu_addr : 12'h000;
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
        cyc++;
        drive_phase();
        #1;
        if (bram_we && ph >= 8 && ph <= 20) we_in_win++;
    endtask

    task automatic wait_ph(input int target);
        for (int i = 0; i < 40 && ph != target; i++) step();
    endtask

    task automatic host_access(input bit we, input logic [11:0] addr, input logic [7:0] wd,
                               output logic [7:0] rd, output bit er);
        int  ack_exp, ack_cyc, we_cnt, we_cyc, we_exp;
        bit  got;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wd;
        host_req   = 1'b1;
        ack_exp = pred_ack(cyc);
        got = 0; we_cnt = 0; we_cyc = -1; ack_cyc = -1; rd = 8'h00; er = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            step();
            if (bram_we) begin
                we_cnt++;
                we_cyc = cyc;
            end
            if (host_ack) begin
                got = 1;
                ack_cyc = cyc;
                rd = host_rdata;
                er = host_err;
            end
        end
        host_req = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL ack_timeout addr=%h: no host_ack within 80 cycles", addr);
        end
        checks++;
        if (ack_cyc !== ack_exp) begin
            failures++;
            $display("FAIL ack_latency addr=%h: ack at cycle %0d, expected %0d", addr, ack_cyc, ack_exp);
        end
`ifdef MCS4_ROM_HOST_WRITE_EN
        we_exp = we ? 1 : 0;
`else
        we_exp = 0;
`endif
        checks++;
        if (we_cnt !== we_exp || (we_exp == 1 && we_cyc !== ack_exp - 2)) begin
            failures++;
            $display("FAIL bram_we addr=%h: %0d pulses (last cycle %0d), expected %0d at cycle %0d",
                     addr, we_cnt, we_cyc, we_exp, ack_exp - 2);
        end
        step();
        checks++;
        if (host_ack !== 1'b0) begin
            failures++;
            $display("FAIL ack_pulse addr=%h: host_ack=%b one cycle after ack, expected 0", addr, host_ack);
        end
    endtask

    task automatic test_reset();
        poc = 1'b1;
        repeat (3) step();
        checks++;
        if ({rom_data, bram_addr, bram_we, bram_wdata, host_ack, host_err, host_rdata} !== 39'd0) begin
            failures++;
            $display("FAIL reset_outputs: rom_data=%h bram_addr=%h we=%b wdata=%h ack=%b err=%b rdata=%h, expected all 0",
                     rom_data, bram_addr, bram_we, bram_wdata, host_ack, host_err, host_rdata);
        end
        poc = 1'b0;
        step();
    endtask

    task automatic test_cpu_fetch();
        cpu_addr = 12'h123;
        wait_ph(7);
        step();
        checks++;
        if (bram_addr !== 12'h123) begin
            failures++;
            $display("FAIL fetch_bram_addr: got %h, expected 123", bram_addr);
        end
        step();
        checks++;
        if (rom_data !== 8'h5A) begin
            failures++;
            $display("FAIL fetch_latency_t1: rom_data=%h, expected 5a (previous word)", rom_data);
        end
        step();
        checks++;
        if (rom_data !== 8'hA5) begin
            failures++;
            $display("FAIL fetch_data_t2: rom_data=%h, expected a5", rom_data);
        end
        wait_ph(25);
        checks++;
        if (rom_data !== 8'hA5 || bram_addr !== 12'h000) begin
            failures++;
            $display("FAIL fetch_hold: rom_data=%h bram_addr=%h, expected a5 / 000", rom_data, bram_addr);
        end
    endtask

    task automatic test_host_write_read();
        logic [7:0] rd;
        bit         er;
        host_access(1'b1, 12'h0FF, 8'h3C, rd, er);
        checks++;
`ifdef MCS4_ROM_HOST_WRITE_EN
        if (er !== 1'b0) begin
            failures++;
            $display("FAIL write_err: host_err=%b, expected 0", er);
        end
        host_access(1'b0, 12'h0FF, 8'h00, rd, er);
        checks++;
        if (rd !== 8'h3C || er !== 1'b0) begin
            failures++;
            $display("FAIL readback_0ff: rdata=%h err=%b, expected 3c / 0", rd, er);
        end
`else
        if (er !== 1'b1) begin
            failures++;
            $display("FAIL write_err: host_err=%b, expected 1", er);
        end
        host_access(1'b0, 12'h0FF, 8'h00, rd, er);
        checks++;
        if (rd !== 8'h11 || er !== 1'b0) begin
            failures++;
            $display("FAIL readback_0ff: rdata=%h err=%b, expected 11 / 0", rd, er);
        end
`endif
    endtask

    task automatic test_write_refused();
        logic [7:0] rd;
        bit         er;
        host_access(1'b0, 12'h010, 8'h00, rd, er);
        checks++;
        if (rd !== 8'h42) begin
            failures++;
            $display("FAIL read_010: rdata=%h, expected 42", rd);
        end
        host_access(1'b1, 12'h010, 8'h99, rd, er);
        checks++;
`ifdef MCS4_ROM_HOST_WRITE_EN
        if (er !== 1'b0) begin
            failures++;
            $display("FAIL write_010_err: host_err=%b, expected 0", er);
        end
        host_access(1'b0, 12'h010, 8'h00, rd, er);
        checks++;
        if (rd !== 8'h99) begin
            failures++;
            $display("FAIL reread_010: rdata=%h, expected 99", rd);
        end
`else
        if (er !== 1'b1 || rd !== 8'h42) begin
            failures++;
            $display("FAIL write_010_refused: err=%b rdata=%h, expected 1 / 42 (unchanged)", er, rd);
        end
        host_access(1'b0, 12'h010, 8'h00, rd, er);
        checks++;
        if (rd !== 8'h42) begin
            failures++;
            $display("FAIL reread_010: rdata=%h, expected 42", rd);
        end
`endif
    endtask

    task automatic test_deferred();
        logic [7:0] rd;
        bit         er;
        wait_ph(8);
        host_access(1'b1, 12'h300, 8'hE1, rd, er);
        checks++;
        if (rom_data !== 8'hA5) begin
            failures++;
            $display("FAIL deferred_rom_data: rom_data=%h, expected a5", rom_data);
        end
        host_access(1'b0, 12'h300, 8'h00, rd, er);
        checks++;
`ifdef MCS4_ROM_HOST_WRITE_EN
        if (rd !== 8'hE1) begin
            failures++;
            $display("FAIL deferred_readback: rdata=%h, expected e1", rd);
        end
`else
        if (rd !== 8'h0D) begin
            failures++;
            $display("FAIL deferred_readback: rdata=%h, expected 0d", rd);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int         a1, a2, e1, e2;
        logic [7:0] r1, r2;
        a1 = -1; a2 = -1; r1 = 8'h00; r2 = 8'h00;
        host_we   = 1'b0;
        host_addr = 12'h201;
        host_req  = 1'b1;
        e1 = pred_ack(cyc);
        for (int i = 0; i < 80 && a1 < 0; i++) begin
            step();
            if (host_ack) begin
                a1 = cyc;
                r1 = host_rdata;
            end
        end
        host_addr = 12'h202;
        e2 = pred_ack(cyc + 1);
        for (int i = 0; i < 80 && a2 < 0; i++) begin
            step();
            if (host_ack) begin
                a2 = cyc;
                r2 = host_rdata;
            end
        end
        host_req = 1'b0;
        checks++;
        if (a1 !== e1 || r1 !== 8'hC3) begin
            failures++;
            $display("FAIL b2b_first: ack cycle %0d rdata=%h, expected cycle %0d rdata c3", a1, r1, e1);
        end
        checks++;
        if (a2 !== e2 || r2 !== 8'h96 || a2 - a1 < 4) begin
            failures++;
            $display("FAIL b2b_second: ack cycle %0d rdata=%h, expected cycle %0d rdata 96 (gap>=4 from %0d)",
                     a2, r2, e2, a1);
        end
        step();
    endtask

    task automatic test_reset_mid_op();
        int acks;
        wait_ph(22);
        host_we    = 1'b1;
        host_addr  = 12'h0AA;
        host_wdata = 8'h00;
        host_req   = 1'b1;
        step();
        checks++;
        if (bram_addr !== 12'h0AA) begin
            failures++;
            $display("FAIL midreset_grant: bram_addr=%h, expected 0aa", bram_addr);
        end
        poc      = 1'b1;
        host_req = 1'b0;
        #1;
        checks++;
        if (bram_we !== 1'b0) begin
            failures++;
            $display("FAIL midreset_we: bram_we=%b during poc, expected 0", bram_we);
        end
        step();
        checks++;
        if ({rom_data, bram_addr, bram_we, bram_wdata, host_ack, host_err, host_rdata} !== 39'd0) begin
            failures++;
            $display("FAIL midreset_outputs: rom_data=%h bram_addr=%h we=%b wdata=%h ack=%b err=%b rdata=%h, expected all 0",
                     rom_data, bram_addr, bram_we, bram_wdata, host_ack, host_err, host_rdata);
        end
        poc  = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (host_ack) acks++;
        end
        checks++;
        if (acks !== 0 || mem[12'h0AA] !== 8'h77) begin
            failures++;
            $display("FAIL midreset_dropped: acks=%0d mem[0aa]=%h, expected 0 / 77", acks, mem[12'h0AA]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        poc        = 1'b1;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = 12'h000;
        host_wdata = 8'h00;
        cpu_addr   = 12'h000;
        mem_init   = 1'b1;
        drive_phase();
        step();
        mem_init   = 1'b0;

        test_reset();
        test_cpu_fetch();
        test_host_write_read();
        test_write_refused();
        test_deferred();
        test_back_to_back();
        test_reset_mid_op();

        checks++;
        if (we_in_win !== 0) begin
            failures++;
            $display("FAIL we_in_window: bram_we high in %0d window cycles, expected 0", we_in_win);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
